// File: rtl/data_mem_mmio_if.sv
// Data-memory port bundle between the core (plus TX sink) and the data_mem_mmio responder.
interface data_mem_mmio_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              mem_wr;
  logic              mem_rd;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              irq_err;

  // core + stream sink side
  modport master (
    output mem_wr, mem_rd, funct3, addr, wr_data, tx_ready,
    input  rd_data, tx_valid, tx_data, irq_err
  );

  // memory/MMIO responder side
  modport slave (
    input  mem_wr, mem_rd, funct3, addr, wr_data, tx_ready,
    output rd_data, tx_valid, tx_data, irq_err
  );
endinterface

// File: rtl/data_mem_mmio.sv
// Data RAM with byte/half/word access plus an MMIO window: TX byte FIFO,
// status register (sticky overflow/misalign) and a free-running cycle counter.
// Reads are combinational so a single-cycle core can finish loads in-cycle.
module data_mem_mmio #(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 9,
  parameter int              FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 9'h1F0
) (
  input logic             clk,
  input logic             reset,
  data_mem_mmio_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int RAM_WORDS = int'(MMIO_BASE) / 4;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int WA_W      = ADDR_W - 2;

  // ---------------- access decode ----------------
  logic [1:0]      size;      // 0 byte, 1 half, 2 word
  logic            align_ok;
  logic [WA_W-1:0] widx;
  logic [WA_W-1:0] mmio_woff;
  logic [1:0]      reg_sel;
  logic            off_hi, is_mmio;
  logic            wr_ok, ram_we, mmio_we, wr_tx, wr_stat, wr_cyc, mis_set;

  // size and alignment legality from funct3; undefined codes are never legal
  always_comb begin
    size     = 2'd0;
    align_ok = 1'b0;
    case (bus.funct3)
      3'b000, 3'b100: begin size = 2'd0; align_ok = 1'b1; end
      3'b001, 3'b101: begin size = 2'd1; align_ok = ~bus.addr[0]; end
      3'b010:         begin size = 2'd2; align_ok = (bus.addr[1:0] == 2'b00); end
      default:        begin size = 2'd0; align_ok = 1'b0; end
    endcase
  end

  assign widx      = bus.addr[ADDR_W-1:2];
  assign is_mmio   = (bus.addr >= MMIO_BASE);
  assign mmio_woff = widx - MMIO_BASE[ADDR_W-1:2];
  assign reg_sel   = mmio_woff[1:0];
  assign off_hi    = (mmio_woff[WA_W-1:2] != '0);

  assign wr_ok   = bus.mem_wr & align_ok;
  assign ram_we  = wr_ok & ~is_mmio;
  assign mmio_we = wr_ok & is_mmio & ~off_hi;
  assign wr_tx   = mmio_we & (reg_sel == 2'd0);
  assign wr_stat = mmio_we & (reg_sel == 2'd1);
  assign wr_cyc  = mmio_we & (reg_sel == 2'd2);
  assign mis_set = (bus.mem_wr | bus.mem_rd) & ~align_ok;

  // ---------------- per-lane store steering ----------------
  logic [NUM_LANES-1:0]        be;
  logic [NUM_LANES-1:0][7:0]   lane_d;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign be[g] = (size == 2'd0) ? (bus.addr[1:0] == 2'(g)) :
                   (size == 2'd1) ? (bus.addr[1] == 1'(g / 2)) : 1'b1;
    assign lane_d[g] = (size == 2'd0) ? bus.wr_data[7:0] :
                       (size == 2'd1) ? bus.wr_data[8*(g%2) +: 8] :
                                        bus.wr_data[8*g +: 8];
  end

  logic [NUM_LANES-1:0][7:0] ram [RAM_WORDS];

  // RAM byte-lane writes; no reset, contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we)
      for (int l = 0; l < NUM_LANES; l++)
        if (be[l]) ram[widx][l] <= lane_d[l];
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]       fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty, full, pop, push, ovf_set;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = ~empty & bus.tx_ready;
  // a full FIFO still takes a byte when the head leaves on the same edge
  assign push    = wr_tx & (~full | pop);
  assign ovf_set = wr_tx & full & ~pop;

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, data only
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= bus.wr_data[7:0];
  end

  assign bus.tx_valid = ~empty;
  assign bus.tx_data  = empty ? 8'h00 : fifo[rd_ptr];

  // ---------------- flags, irq, cycle counter ----------------
  logic        ovf_q, mis_q, irq_q, ovf_nxt, mis_nxt;
  logic [31:0] cyc_q;

  // a new event in the same cycle as its W1C keeps the flag set
  assign ovf_nxt = ovf_set | (ovf_q & ~(wr_stat & bus.wr_data[2]));
  assign mis_nxt = mis_set | (mis_q & ~(wr_stat & bus.wr_data[3]));

  // sticky flags with irq registered alongside them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      mis_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_nxt;
      mis_q <= mis_nxt;
      irq_q <= ovf_nxt | mis_nxt;
    end
  end

  assign bus.irq_err = irq_q;

  // free-running counter; a write clears it instead of incrementing
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cyc_q <= '0;
    else if (wr_cyc) cyc_q <= '0;
    else             cyc_q <= cyc_q + 32'd1;
  end

  // ---------------- load path ----------------
  logic [31:0]               status_w, mmio_word;
  logic [NUM_LANES-1:0][7:0] word_r;
  logic [7:0]                byte_r;
  logic [15:0]               half_r;

  assign status_w = {23'd0, 5'(count), mis_q, ovf_q, full, empty};

  // MMIO register select; TXDATA and reserved slots read as zero
  always_comb begin
    mmio_word = 32'd0;
    if (!off_hi)
      case (reg_sel)
        2'd1:    mmio_word = status_w;
        2'd2:    mmio_word = cyc_q;
        default: mmio_word = 32'd0;
      endcase
  end

  assign word_r = is_mmio ? mmio_word : ram[widx];
  assign byte_r = word_r[bus.addr[1:0]];
  assign half_r = bus.addr[1] ? {word_r[3], word_r[2]} : {word_r[1], word_r[0]};

  // lane extraction and extension; illegal or idle loads return zero
  always_comb begin
    bus.rd_data = '0;
    if (bus.mem_rd && align_ok)
      case (bus.funct3)
        3'b000:  bus.rd_data = {{24{byte_r[7]}}, byte_r};
        3'b100:  bus.rd_data = {24'd0, byte_r};
        3'b001:  bus.rd_data = {{16{half_r[15]}}, half_r};
        3'b101:  bus.rd_data = {16'd0, half_r};
        3'b010:  bus.rd_data = word_r;
        default: bus.rd_data = '0;
      endcase
  end
endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench: byte-addressed RAM model, queue-based FIFO model.
module tb_data_mem_mmio;
  localparam int TXD  = 'h1F0;
  localparam int STAT = 'h1F4;
  localparam int CYC  = 'h1F8;
  localparam int RSV  = 'h1FC;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_mmio_if #(.ADDR_W(9), .DATA_W(32)) bus();

  data_mem_mmio #(.DATA_W(32), .ADDR_W(9), .FIFO_DEPTH(8), .MMIO_BASE(9'h1F0)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_m [0:495];
  logic [7:0] fifo_m [$];
  bit ovf_m, mis_m;

  // ---------------- reference model ----------------
  function automatic bit m_aligned(int a, logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return (a % 2) == 0;
      3'b010:         return (a % 4) == 0;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(int a, logic [2:0] f);
    logic [15:0] h;
    if (!m_aligned(a, f)) return 32'd0;
    case (f)
      3'b000: return {{24{ram_m[a][7]}}, ram_m[a]};
      3'b100: return {24'd0, ram_m[a]};
      3'b001: begin h = {ram_m[a+1], ram_m[a]}; return {{16{h[15]}}, h}; end
      3'b101: begin h = {ram_m[a+1], ram_m[a]}; return {16'd0, h}; end
      default: return {ram_m[a+3], ram_m[a+2], ram_m[a+1], ram_m[a]};
    endcase
  endfunction

  task automatic m_store(int a, logic [31:0] d, logic [2:0] f);
    int n;
    if (!m_aligned(a, f)) begin mis_m = 1'b1; return; end
    n = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) ram_m[a+i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] m_status();
    int c;
    c = fifo_m.size();
    return (c << 4) | (int'(mis_m) << 3) | (int'(ovf_m) << 2) |
           (int'(c == DEPTH) << 1) | int'(c == 0);
  endfunction

  // ---------------- bus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_wr = 1'b0; bus.mem_rd = 1'b0; bus.funct3 = 3'b010;
    bus.addr = '0; bus.wr_data = '0;
  endtask

  task automatic st(int a, logic [31:0] d, logic [2:0] f);
    bus.mem_wr = 1'b1; bus.mem_rd = 1'b0; bus.addr = 9'(a);
    bus.wr_data = d; bus.funct3 = f;
    tick();
    bus.mem_wr = 1'b0;
  endtask

  task automatic ld(int a, logic [2:0] f, output logic [31:0] d);
    bus.mem_rd = 1'b1; bus.mem_wr = 1'b0; bus.addr = 9'(a); bus.funct3 = f;
    #1;
    d = bus.rd_data;
    bus.mem_rd = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] r;
    idle();
    bus.tx_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.irq_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h irq=%b required 0/00/0",
               bus.tx_valid, bus.tx_data, bus.irq_err);
    end
    reset = 1'b0;
    ld(STAT, 3'b010, r);
    checks++;
    if (r !== 32'h1) begin errors++; $display("FAIL reset_status: got %h required %h", r, 32'h1); end
    ld(CYC, 3'b010, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_cycles: got %h required 0", r); end
    tick(); tick();
    ld(CYC, 3'b010, r);
    checks++;
    if (r !== 32'd2) begin errors++; $display("FAIL cycles_after_reset: got %h required 2", r); end
  endtask

  task automatic test_ram_init();
    logic [31:0] d;
    for (int w = 0; w < 124; w++) begin
      d = $urandom;
      st(w * 4, d, 3'b010);
      m_store(w * 4, d, 3'b010);
    end
  endtask

  task automatic test_spec_vectors();
    logic [31:0] r;
    st('h010, 32'h12345678, 3'b010); m_store('h010, 32'h12345678, 3'b010);
    ld('h011, 3'b000, r); checks++;
    if (r !== 32'h00000056) begin errors++; $display("FAIL lb_011: got %h required 00000056", r); end
    ld('h012, 3'b001, r); checks++;
    if (r !== 32'h00001234) begin errors++; $display("FAIL lh_012: got %h required 00001234", r); end
    ld('h010, 3'b010, r); checks++;
    if (r !== 32'h12345678) begin errors++; $display("FAIL lw_010: got %h required 12345678", r); end
    tick();
    st('h013, 32'h00000080, 3'b000); m_store('h013, 32'h80, 3'b000);
    ld('h013, 3'b000, r); checks++;
    if (r !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_neg: got %h required ffffff80", r); end
    ld('h013, 3'b100, r); checks++;
    if (r !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h required 00000080", r); end
    ld('h010, 3'b010, r); checks++;
    if (r !== 32'h80345678) begin errors++; $display("FAIL sb_lanes: got %h required 80345678", r); end
    bus.addr = 9'h010; bus.funct3 = 3'b010; bus.mem_rd = 1'b0; #1;
    checks++;
    if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL rd_idle: got %h required 0", bus.rd_data); end
    tick();
  endtask

  task automatic test_misalign();
    logic [31:0] r, e;
    st('h011, 32'h0000BEEF, 3'b001); m_store('h011, 32'hBEEF, 3'b001);
    e = m_load('h010, 3'b010);
    ld('h010, 3'b010, r); checks++;
    if (r !== e) begin errors++; $display("FAIL sh_misalign_ram: got %h required %h", r, e); end
    ld(STAT, 3'b010, r); checks++;
    if (r !== m_status()) begin errors++; $display("FAIL misalign_status: got %h required %h", r, m_status()); end
    checks++;
    if (bus.irq_err !== 1'b1) begin errors++; $display("FAIL misalign_irq: got %b required 1", bus.irq_err); end
    tick();
    st(STAT, 32'h8, 3'b010); mis_m = 1'b0;
    ld(STAT, 3'b010, r); checks++;
    if (r !== m_status()) begin errors++; $display("FAIL w1c_status: got %h required %h", r, m_status()); end
    checks++;
    if (bus.irq_err !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b required 0", bus.irq_err); end
    // misaligned word load and undefined funct3 load, held across an edge
    ld('h012, 3'b010, r); checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL lw_misalign: got %h required 0", r); end
    bus.mem_rd = 1'b1; bus.addr = 9'h010; bus.funct3 = 3'b011; #1;
    checks++;
    if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL undef_load: got %h required 0", bus.rd_data); end
    tick(); bus.mem_rd = 1'b0; mis_m = 1'b1;
    checks++;
    if (bus.irq_err !== 1'b1) begin errors++; $display("FAIL undef_irq: got %b required 1", bus.irq_err); end
    st(STAT, 32'h8, 3'b010); mis_m = 1'b0;
  endtask

  task automatic test_rw_same();
    logic [31:0] e_old, r;
    e_old = m_load('h020, 3'b010);
    bus.mem_wr = 1'b1; bus.mem_rd = 1'b1; bus.addr = 9'h020;
    bus.funct3 = 3'b010; bus.wr_data = 32'hCAFEF00D; #1;
    checks++;
    if (bus.rd_data !== e_old) begin errors++; $display("FAIL rw_pre_store: got %h required %h", bus.rd_data, e_old); end
    tick(); bus.mem_wr = 1'b0; bus.mem_rd = 1'b0;
    m_store('h020, 32'hCAFEF00D, 3'b010);
    ld('h020, 3'b010, r); checks++;
    if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_post_store: got %h required cafef00d", r); end
    tick();
  endtask

  task automatic test_ram_random();
    logic [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] f;
    logic [31:0] r, e, d;
    int a;
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(0, 'h1EC));
      if ($urandom_range(0, 3) != 0) begin
        f = lf[$urandom_range(0, 4)];
        if (f[0]) a = a & ~1;
        if (f[1]) a = a & ~3;
      end else f = lf[$urandom_range(0, 2)];
      if ($urandom_range(0, 1) == 0) begin
        e = m_load(a, f);
        ld(a, f, r); checks++;
        if (r !== e) begin errors++; $display("FAIL rand_load a=%h f=%b: got %h required %h", a, f, r, e); end
        tick();
      end else begin
        d = $urandom;
        st(a, d, f); m_store(a, d, f);
      end
    end
    ld(STAT, 3'b010, r); checks++;
    if (r !== m_status()) begin errors++; $display("FAIL rand_status: got %h required %h", r, m_status()); end
    tick();
    st(STAT, 32'hC, 3'b010); mis_m = 1'b0; ovf_m = 1'b0;
  endtask

  task automatic test_mmio_regs();
    logic [31:0] r;
    st(RSV, 32'hFFFFFFFF, 3'b010);
    ld(TXD, 3'b010, r); checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h required 0", r); end
    ld(RSV, 3'b010, r); checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h required 0", r); end
    ld(STAT, 3'b100, r); checks++;
    if (r !== 32'h1) begin errors++; $display("FAIL status_lbu: got %h required 1", r); end
    tick();
  endtask

  task automatic drain(string name, int n);
    logic [7:0] e;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = fifo_m.pop_front();
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got valid=%b data=%h required 1/%h", name, i, bus.tx_valid, bus.tx_data, e);
      end
      tick();
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] r;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      st(TXD, 32'h41 + i, 3'b000);
      if (fifo_m.size() < DEPTH) fifo_m.push_back(8'(8'h41 + i)); else ovf_m = 1'b1;
    end
    ld(STAT, 3'b010, r); checks++;
    if (r !== 32'h86) begin errors++; $display("FAIL ovf_status: got %h required 00000086", r); end
    checks++;
    if (bus.irq_err !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b required 1", bus.irq_err); end
    drain("ovf_drain", 8);
    checks++;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b required 0", bus.tx_valid); end
    st(STAT, 32'h4, 3'b010); ovf_m = 1'b0;
    ld(STAT, 3'b010, r); checks++;
    if (r !== 32'h1 || bus.irq_err !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %h irq=%b required 00000001 irq=0", r, bus.irq_err);
    end
    tick();
  endtask

  task automatic test_push_pop_full();
    logic [31:0] r;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      st(TXD, 32'h10 + i, 3'b000); fifo_m.push_back(8'(8'h10 + i));
    end
    bus.tx_ready = 1'b1;
    st(TXD, 32'h5A, 3'b000);
    bus.tx_ready = 1'b0;
    void'(fifo_m.pop_front()); fifo_m.push_back(8'h5A);
    ld(STAT, 3'b010, r); checks++;
    if (r !== m_status()) begin errors++; $display("FAIL full_pushpop_status: got %h required %h", r, m_status()); end
    tick();
    drain("full_pushpop_order", DEPTH);
  endtask

  task automatic test_fifo_random();
    logic [31:0] r;
    bit do_push, rdy;
    logic [7:0] b, e;
    for (int i = 0; i < 200; i++) begin
      do_push = ($urandom_range(0, 99) < 60);
      rdy     = ($urandom_range(0, 99) < 40);
      b = 8'($urandom);
      e = (fifo_m.size() != 0) ? fifo_m[0] : 8'h00;
      checks++;
      if (bus.tx_valid !== (fifo_m.size() != 0) || bus.tx_data !== e) begin
        errors++;
        $display("FAIL rand_fifo[%0d]: got valid=%b data=%h required %b/%h",
                 i, bus.tx_valid, bus.tx_data, fifo_m.size() != 0, e);
      end
      bus.tx_ready = rdy;
      bus.mem_wr = do_push; bus.addr = 9'(TXD); bus.funct3 = 3'b000; bus.wr_data = {24'h0, b};
      tick();
      bus.mem_wr = 1'b0;
      if (rdy && fifo_m.size() != 0) void'(fifo_m.pop_front());
      if (do_push) begin
        if (fifo_m.size() < DEPTH) fifo_m.push_back(b); else ovf_m = 1'b1;
      end
    end
    bus.tx_ready = 1'b0;
    ld(STAT, 3'b010, r); checks++;
    if (r !== m_status()) begin errors++; $display("FAIL rand_fifo_status: got %h required %h", r, m_status()); end
    tick();
    drain("rand_fifo_drain", fifo_m.size());
    st(STAT, 32'h4, 3'b010); ovf_m = 1'b0;
  endtask

  task automatic test_cycles();
    logic [31:0] r;
    st(CYC, $urandom, 3'b010);
    tick(); tick(); tick();
    ld(CYC, 3'b010, r); checks++;
    if (r !== 32'd3) begin errors++; $display("FAIL cycles_clear: got %h required 3", r); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) st(TXD, 32'h60 + i, 3'b000);
    st('h001, 32'h0, 3'b010);
    reset = 1'b1; #1;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.irq_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b data=%h irq=%b required 0/00/0",
               bus.tx_valid, bus.tx_data, bus.irq_err);
    end
    tick();
    reset = 1'b0;
    fifo_m.delete(); ovf_m = 1'b0; mis_m = 1'b0;
    ld(STAT, 3'b010, r); checks++;
    if (r !== 32'h1) begin errors++; $display("FAIL reset_mid_status: got %h required 1", r); end
    ld(CYC, 3'b010, r); checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_mid_cycles: got %h required 0", r); end
    tick();
  endtask

  initial begin
    test_reset();
    test_ram_init();
    test_spec_vectors();
    test_misalign();
    test_rw_same();
    test_ram_random();
    test_mmio_regs();
    test_fifo_overflow();
    test_push_pop_full();
    test_fifo_random();
    test_cycles();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
